// File: rtl/vector_pkg.sv
// Shared definitions for the point stream decoder.
//   COORD_W_DEFAULT : default coordinate width in bits
//   DONE_BYTE       : byte value that, repeated across a whole word, marks end of frame
//   rx_state_t      : receiver FSM states
//   point_bytes()   : bytes per point word for a given coordinate width
//   x_lsb/lit_pos() : field offsets inside a decoded word (y always starts at bit 0)
package vector_pkg;

   localparam int COORD_W_DEFAULT = 12;
   localparam logic [7:0] DONE_BYTE = 8'h01;

   typedef enum logic {
      IDLE = 1'b0,
      RECV = 1'b1
   } rx_state_t;

   function automatic int point_bytes(input int coord_w);
      return (2 * coord_w + 1 + 7) / 8;
   endfunction

   function automatic int x_lsb(input int coord_w);
      return coord_w;
   endfunction

   function automatic int lit_pos(input int coord_w);
      return 2 * coord_w;
   endfunction

endpackage

// File: rtl/point_stream_decoder_if.sv
// Bundle of the byte-receive side and the point-emit side of the decoder.
//   rx_valid/rx_byte : received UART byte strobe and data
//   ready            : downstream line engine can take a point
//   x/y/draw/jump    : emitted target coordinate and lit/blanked move pulse
//   frame_done       : end-of-frame pulse
//   receiving        : receiver is inside a word stream
//   overflow/fill    : sticky drop flag and buffer occupancy
// Modports: slave = decoder side, master = source/sink side.
interface point_stream_decoder_if #(
   parameter int COORD_W    = vector_pkg::COORD_W_DEFAULT,
   parameter int FIFO_DEPTH = 16
);
   logic                          rx_valid;
   logic [7:0]                    rx_byte;
   logic                          ready;
   logic [COORD_W-1:0]            x;
   logic [COORD_W-1:0]            y;
   logic                          draw;
   logic                          jump;
   logic                          frame_done;
   logic                          receiving;
   logic                          overflow;
   logic [$clog2(FIFO_DEPTH):0]   fill;

   modport slave (
      input  rx_valid, rx_byte, ready,
      output x, y, draw, jump, frame_done, receiving, overflow, fill
   );

   modport master (
      output rx_valid, rx_byte, ready,
      input  x, y, draw, jump, frame_done, receiving, overflow, fill
   );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO for decoded point words.
//   clk, reset : clock and synchronous active-high reset
//   push/wdata : write request and data (accepted when not full, or when a pop frees a slot)
//   pop/rdata  : read request and head-of-queue data (rdata is valid whenever not empty)
//   full/empty : occupancy flags
//   count      : current occupancy
module sync_fifo #(
   parameter int WIDTH = 25,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count_q;
   logic             do_push;
   logic             do_pop;

   // DEPTH is a power of two, so the count MSB alone means full
   assign full    = count_q[AW];
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rdata   = mem[rd_ptr];
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/point_stream_decoder.sv
// Decodes a UART byte stream into vector display points and paces them out
// to the line engine.
//   clk, reset : clock and synchronous active-high reset
//   bus        : point_stream_decoder_if slave (rx bytes in, points/status out)
//
// state | meaning
// IDLE  | between frames; 0x00 bytes are discarded, first nonzero byte opens a word
// RECV  | assembling point words MSB-first; an all-DONE_BYTE word closes the frame
module point_stream_decoder
   import vector_pkg::*;
#(
   parameter int COORD_W    = COORD_W_DEFAULT,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   point_stream_decoder_if.slave bus
);
   localparam int PB      = point_bytes(COORD_W);
   localparam int WORD_W  = 2 * COORD_W + 1;
   localparam int ASM_W   = PB * 8;
   localparam int X_LSB   = x_lsb(COORD_W);
   localparam int LIT_POS = lit_pos(COORD_W);
   localparam int FILL_W  = $clog2(FIFO_DEPTH) + 1;
   localparam logic [ASM_W-1:0] DONE_WORD = {PB{DONE_BYTE}};
   localparam logic [2:0]       LAST_IDX  = 3'(PB - 1);

   rx_state_t          state_q, state_d;
   logic [2:0]         byte_cnt_q, byte_cnt_d;
   // holds the bytes already received; the current byte completes the word
   logic [ASM_W-9:0]   asm_q, asm_d;
   logic [ASM_W-1:0]   word;
   logic               take;
   logic               push;
   logic               is_done;

   logic               pop;
   logic [WORD_W-1:0]  head;
   logic               full;
   logic               empty;
   logic [FILL_W-1:0]  count;

   logic               cooldown_q;
   logic               frame_done_q;
   logic               overflow_q;
   logic               draw_q;
   logic               jump_q;
   logic [COORD_W-1:0] x_q;
   logic [COORD_W-1:0] y_q;

   assign word = {asm_q, bus.rx_byte};

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      asm_d      = asm_q;
      take       = 1'b0;
      push       = 1'b0;
      is_done    = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.rx_valid && (bus.rx_byte != 8'h00)) begin
               take    = 1'b1;
               state_d = RECV;
            end
         end
         RECV: begin
            take = bus.rx_valid;
         end
         default: state_d = IDLE;
      endcase
      if (take) begin
         asm_d = word[ASM_W-9:0];
         if (byte_cnt_q == LAST_IDX) begin
            byte_cnt_d = '0;
            if (word == DONE_WORD) begin
               is_done = 1'b1;
               state_d = IDLE;
            end else begin
               push = 1'b1;
            end
         end else begin
            byte_cnt_d = byte_cnt_q + 3'd1;
         end
      end
   end

   // one free cycle after every pop lets the line engine drop ready in time
   assign pop = !empty && bus.ready && !cooldown_q;

   sync_fifo #(
      .WIDTH (WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .wdata (word[WORD_W-1:0]),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         byte_cnt_q   <= '0;
         asm_q        <= '0;
         cooldown_q   <= 1'b0;
         frame_done_q <= 1'b0;
         overflow_q   <= 1'b0;
         draw_q       <= 1'b0;
         jump_q       <= 1'b0;
         x_q          <= '0;
         y_q          <= '0;
      end else begin
         byte_cnt_q   <= byte_cnt_d;
         asm_q        <= asm_d;
         cooldown_q   <= pop;
         frame_done_q <= is_done;
         draw_q       <= pop && head[LIT_POS];
         jump_q       <= pop && !head[LIT_POS];
         if (push && full && !pop) begin
            overflow_q <= 1'b1;
         end
         if (pop) begin
            x_q <= head[X_LSB +: COORD_W];
            y_q <= head[COORD_W-1:0];
         end
      end
   end

   assign bus.x          = x_q;
   assign bus.y          = y_q;
   assign bus.draw       = draw_q;
   assign bus.jump       = jump_q;
   assign bus.frame_done = frame_done_q;
   assign bus.receiving  = (state_q == RECV);
   assign bus.overflow   = overflow_q;
   assign bus.fill       = count;

endmodule

// File: tb/tb_point_stream_decoder.sv
module tb_point_stream_decoder;
   import vector_pkg::*;

   localparam int CW_A    = 12;
   localparam int DEPTH_A = 16;
   localparam int PB_A    = 4;   // ceil(25/8)
   localparam int CW_B    = 16;
   localparam int DEPTH_B = 4;

   typedef struct {
      logic [15:0] x;
      logic [15:0] y;
      logic        lit;
   } point_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   point_stream_decoder_if #(.COORD_W(CW_A), .FIFO_DEPTH(DEPTH_A)) ifa ();
   point_stream_decoder_if #(.COORD_W(CW_B), .FIFO_DEPTH(DEPTH_B)) ifb ();

   point_stream_decoder #(.COORD_W(CW_A), .FIFO_DEPTH(DEPTH_A)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (ifa)
   );

   point_stream_decoder #(.COORD_W(CW_B), .FIFO_DEPTH(DEPTH_B)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (ifb)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model (byte stream -> expected points) ----------------
   point_t      exp_q[$];
   logic [7:0]  m_bytes[$];
   bit          m_in_word = 0;
   bit          m_overflow = 0;
   int          m_frames = 0;
   int          m_points_total = 0;

   function automatic point_t decode(input longint unsigned w, input int cw);
      point_t p;
      longint unsigned mask;
      mask  = (64'd1 << cw) - 64'd1;
      p.y   = 16'(w & mask);
      p.x   = 16'((w >> cw) & mask);
      p.lit = 1'((w >> (2 * cw)) & 64'd1);
      return p;
   endfunction

   function automatic void mdl_byte(input logic [7:0] b);
      longint unsigned w;
      bit all_one;
      if (!m_in_word && b == 8'h00) return;
      m_in_word = 1;
      m_bytes.push_back(b);
      if (m_bytes.size() < PB_A) return;
      w = 0;
      all_one = 1;
      foreach (m_bytes[i]) begin
         w = (w << 8) | longint'(m_bytes[i]);
         if (m_bytes[i] != 8'h01) all_one = 0;
      end
      m_bytes.delete();
      if (all_one) begin
         m_frames++;
         m_in_word = 0;
         return;
      end
      if (exp_q.size() == DEPTH_A) m_overflow = 1;
      else begin
         exp_q.push_back(decode(w, CW_A));
         m_points_total++;
      end
   endfunction

   // ---------------- output monitor for dut_a ----------------
   bit     mon_en = 0;
   int     pulses = 0;
   int     last_pulse_cyc = -100;
   int     seen_frames = 0;
   point_t mon_p;

   always @(negedge clk) begin
      if (mon_en) begin
         check("draw_jump_exclusive", ifa.draw & ifa.jump, 0);
         if (ifa.frame_done) seen_frames++;
         if (ifa.draw || ifa.jump) begin
            check("pulse_spacing", (cyc - last_pulse_cyc) >= 2, 1);
            last_pulse_cyc = cyc;
            pulses++;
            check("pulse_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               mon_p = exp_q.pop_front();
               check("pulse_x", ifa.x, mon_p.x[CW_A-1:0]);
               check("pulse_y", ifa.y, mon_p.y[CW_A-1:0]);
               check("pulse_draw_is_lit", ifa.draw, mon_p.lit);
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   int last_send_cyc = 0;

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_a(input logic [7:0] b);
      ifa.rx_valid  = 1'b1;
      ifa.rx_byte   = b;
      last_send_cyc = cyc;
      mdl_byte(b);
      @(posedge clk);
      #1;
      ifa.rx_valid = 1'b0;
   endtask

   task automatic send_b(input logic [7:0] b);
      ifb.rx_valid = 1'b1;
      ifb.rx_byte  = b;
      @(posedge clk);
      #1;
      ifb.rx_valid = 1'b0;
   endtask

   task automatic send_word_a(input logic [31:0] w);
      for (int i = 3; i >= 0; i--) send_a(w[i*8 +: 8]);
   endtask

   task automatic wait_drain(input int max_cyc);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < max_cyc) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain_within_budget", exp_q.size(), 0);
      idle(2);
   endtask

   function automatic logic [31:0] gen_word(input logic lit);
      logic [31:0] w;
      w = {7'd0, lit, 12'($urandom), 12'($urandom)};
      if (w == 32'h01010101) w[0] = 1'b0;
      return w;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   int     base;
   bit     got;
   point_t pb;

   initial begin
      reset = 1'b1;
      ifa.rx_valid = 1'b0; ifa.rx_byte = 8'h00; ifa.ready = 1'b0;
      ifb.rx_valid = 1'b0; ifb.rx_byte = 8'h00; ifb.ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_x", ifa.x, 0);
      check("rst_y", ifa.y, 0);
      check("rst_draw", ifa.draw, 0);
      check("rst_jump", ifa.jump, 0);
      check("rst_frame_done", ifa.frame_done, 0);
      check("rst_receiving", ifa.receiving, 0);
      check("rst_overflow", ifa.overflow, 0);
      check("rst_fill", ifa.fill, 0);
      check("rst_b_fill", ifb.fill, 0);
      mon_en = 1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      ifa.ready = 1'b1;
      ifb.ready = 1'b1;

      // leading zeros ignored, then a word whose lead byte 0x01 also sets the lit bit
      send_a(8'h00);
      send_a(8'h00);
      check("idle_ignores_zero", ifa.receiving, 0);
      send_word_a(32'h01234567);
      check("recv_after_word", ifa.receiving, 1);
      idle(4);
      check("latency_2_cycles", last_pulse_cyc, last_send_cyc + 2);
      check("s1_x_held", ifa.x, 12'h234);
      check("s1_y_held", ifa.y, 12'h567);

      // wide coordinates: 5-byte words
      send_b(8'h01); send_b(8'h23); send_b(8'h45); send_b(8'h67); send_b(8'h89);
      got = 0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         if (ifb.draw || ifb.jump) got = 1;
      end
      pb = decode(40'h0123456789, CW_B);
      check("b_pulse_seen", got, 1);
      check("b_x", ifb.x, pb.x);
      check("b_y", ifb.y, pb.y);
      check("b_draw", ifb.draw, pb.lit);
      check("b_jump", ifb.jump, !pb.lit);
      @(posedge clk);
      #1;

      // lit word
      send_word_a(32'h01FFF001);
      idle(4);
      check("s3_x_held", ifa.x, 12'hFFF);
      check("s3_y_held", ifa.y, 12'h001);

      // all-zero word inside RECV is a real point; all-0x01 word ends the frame
      send_word_a(32'h00000000);
      idle(4);
      check("zero_word_x", ifa.x, 0);
      check("zero_word_y", ifa.y, 0);
      send_word_a(32'h01010101);
      idle(3);
      check("frame_done_count", seen_frames, m_frames);
      check("idle_after_done", ifa.receiving, 0);
      check("done_pushes_nothing", ifa.fill, 0);
      wait_drain(20);

      // overflow: 17 points with ready low
      ifa.ready = 1'b0;
      send_word_a(gen_word(1'b1));
      for (int i = 1; i < 17; i++) send_word_a(gen_word(1'($urandom)));
      idle(2);
      check("ovf_fill", ifa.fill, exp_q.size());
      check("ovf_fill_full", ifa.fill, DEPTH_A);
      check("ovf_flag", ifa.overflow, m_overflow);
      base = pulses;
      ifa.ready = 1'b1;
      wait_drain(80);
      check("ovf_drain_pulses", pulses - base, 16);
      check("ovf_fill_empty", ifa.fill, 0);
      check("ovf_sticky", ifa.overflow, 1);

      // random byte stream with random gaps and random ready
      for (int i = 0; i < 64; i++) begin
         ifa.ready = 1'($urandom_range(0, 1));
         send_a(8'($urandom_range(0, 255)));
         idle($urandom_range(0, 2));
      end
      ifa.ready = 1'b1;
      wait_drain(100);
      check("rand_frames", seen_frames, m_frames);

      // reset in the middle of a word
      send_a(8'h01);
      send_a(8'h22);
      reset = 1'b1;
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("inrst_xy", {ifa.x, ifa.y}, 0);
         check("inrst_pulses", {ifa.draw, ifa.jump, ifa.frame_done}, 0);
         check("inrst_status", {ifa.receiving, ifa.overflow, ifa.fill}, 0);
      end
      m_in_word = 0;
      m_bytes.delete();
      m_overflow = 0;
      exp_q.delete();
      @(posedge clk);
      #1;
      reset = 1'b0;
      base = pulses;
      send_word_a(32'h01ABCDEF);
      wait_drain(20);
      check("post_rst_one_point", pulses - base, 1);
      check("post_rst_x", ifa.x, 12'hABC);
      check("post_rst_y", ifa.y, 12'hDEF);
      check("post_rst_overflow", ifa.overflow, m_overflow);
      check("total_points", pulses, m_points_total);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
